// File: rtl/io_port_router_if.sv
// Bundle of CPU port-bus and peripheral-channel signals around the I/O port router.
// The router takes the slave view; the CPU/peripheral environment takes the master view.
interface io_port_router_if #(
  parameter int NCH    = 4,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0]     port_id;
  logic                  write_strobe;
  logic                  read_strobe;
  logic [DATA_W-1:0]     out_port;
  logic [DATA_W-1:0]     in_port;
  logic                  cpu_ready;
  logic [NCH-1:0]        ch_sel;
  logic                  ch_we;
  logic                  ch_re;
  logic [ADDR_W-1:0]     dir;
  logic [DATA_W-1:0]     ch_wdata;
  logic [NCH*DATA_W-1:0] ch_rdata;
  logic [NCH-1:0]        ch_ack;
  logic                  err_timeout;
  logic                  err_unmapped;
  logic                  err_clr;

  modport master (
    output port_id, write_strobe, read_strobe, out_port, ch_rdata, ch_ack, err_clr,
    input  in_port, cpu_ready, ch_sel, ch_we, ch_re, dir, ch_wdata, err_timeout, err_unmapped
  );

  modport slave (
    input  port_id, write_strobe, read_strobe, out_port, ch_rdata, ch_ack, err_clr,
    output in_port, cpu_ready, ch_sel, ch_we, ch_re, dir, ch_wdata, err_timeout, err_unmapped
  );
endinterface

// File: rtl/io_port_router.sv
// Decodes CPU port accesses onto address windows of NCH peripheral channels,
// waits for the selected channel's ack (bounded by TIMEOUT) and returns read data.
module io_port_router #(
  parameter int                    NCH     = 4,
  parameter int                    ADDR_W  = 8,
  parameter int                    DATA_W  = 8,
  parameter logic [NCH*ADDR_W-1:0] CH_BASE = {8'd40, 8'd17, 8'd5, 8'd1},
  parameter logic [NCH*ADDR_W-1:0] CH_LAST = {8'd50, 8'd27, 8'd7, 8'd4},
  parameter int                    TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            reset,
  io_port_router_if.slave bus
);
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

  state_t            state_r;
  state_t            next_state_s;
  logic              hit_s;
  logic [IDX_W-1:0]  hit_idx_s;
  logic [ADDR_W-1:0] base_s;
  logic              start_s;
  logic              ack_s;
  logic              expire_s;
  logic              miss_s;
  logic              timeout_s;
  logic [DATA_W-1:0] rdata_s;
  logic [IDX_W-1:0]  sel_idx_r;
  logic [7:0]        cnt_r;
  logic [DATA_W-1:0] in_port_r;
  logic              cpu_ready_r;
  logic [NCH-1:0]    ch_sel_r;
  logic              ch_we_r;
  logic              ch_re_r;
  logic [ADDR_W-1:0] dir_r;
  logic [DATA_W-1:0] ch_wdata_r;
  logic              err_timeout_r;
  logic              err_unmapped_r;

  assign start_s   = bus.write_strobe | bus.read_strobe;
  assign expire_s  = (cnt_r == 8'(TIMEOUT - 1));
  assign miss_s    = (state_r == IDLE) && start_s && !hit_s;
  assign timeout_s = (state_r == ACCESS) && !ack_s && expire_s;

  // Window decode; scanning from the top index down lets the lowest matching window win.
  always_comb begin
    hit_s     = 1'b0;
    hit_idx_s = {IDX_W{1'b0}};
    base_s    = {ADDR_W{1'b0}};
    for (int i = NCH - 1; i >= 0; i--) begin
      if ((bus.port_id >= CH_BASE[i*ADDR_W +: ADDR_W]) &&
          (bus.port_id <= CH_LAST[i*ADDR_W +: ADDR_W])) begin
        hit_s     = 1'b1;
        hit_idx_s = IDX_W'(i);
        base_s    = CH_BASE[i*ADDR_W +: ADDR_W];
      end else begin
        hit_s     = hit_s;
      end
    end
  end

  // Only the latched channel's ack and read data are looked at.
  always_comb begin
    ack_s   = 1'b0;
    rdata_s = {DATA_W{1'b0}};
    for (int i = 0; i < NCH; i++) begin
      if (sel_idx_r == IDX_W'(i)) begin
        ack_s   = bus.ch_ack[i];
        rdata_s = bus.ch_rdata[i*DATA_W +: DATA_W];
      end else begin
        ack_s   = ack_s;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_s) begin
          next_state_s = hit_s ? ACCESS : DONE;
        end else begin
          next_state_s = IDLE;
        end
      end
      ACCESS: begin
        if (ack_s || expire_s) begin
          next_state_s = DONE;
        end else begin
          next_state_s = ACCESS;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Channel-side outputs, read data capture and the completion pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_port_r   <= {DATA_W{1'b0}};
      cpu_ready_r <= 1'b0;
      ch_sel_r    <= {NCH{1'b0}};
      ch_we_r     <= 1'b0;
      ch_re_r     <= 1'b0;
      dir_r       <= {ADDR_W{1'b0}};
      ch_wdata_r  <= {DATA_W{1'b0}};
      sel_idx_r   <= {IDX_W{1'b0}};
      cnt_r       <= 8'd0;
    end else begin
      cpu_ready_r <= (next_state_s == DONE);
      case (state_r)
        IDLE: begin
          if (start_s && hit_s) begin
            ch_sel_r   <= NCH'(1'b1) << hit_idx_s;
            ch_we_r    <= bus.write_strobe;
            ch_re_r    <= ~bus.write_strobe;
            dir_r      <= bus.port_id - base_s;
            ch_wdata_r <= bus.out_port;
            sel_idx_r  <= hit_idx_s;
            cnt_r      <= 8'd0;
          end else if (start_s && !bus.write_strobe) begin
            in_port_r  <= {DATA_W{1'b0}};
          end
        end
        ACCESS: begin
          if (ack_s || expire_s) begin
            ch_sel_r <= {NCH{1'b0}};
            ch_we_r  <= 1'b0;
            ch_re_r  <= 1'b0;
            if (ch_re_r) begin
              in_port_r <= ack_s ? rdata_s : {DATA_W{1'b1}};
            end
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  // Sticky error flags; a clear request beats a simultaneous set.
  always_ff @(posedge clk) begin
    if (reset || bus.err_clr) begin
      err_timeout_r  <= 1'b0;
      err_unmapped_r <= 1'b0;
    end else begin
      err_timeout_r  <= err_timeout_r | timeout_s;
      err_unmapped_r <= err_unmapped_r | miss_s;
    end
  end

  assign bus.in_port      = in_port_r;
  assign bus.cpu_ready    = cpu_ready_r;
  assign bus.ch_sel       = ch_sel_r;
  assign bus.ch_we        = ch_we_r;
  assign bus.ch_re        = ch_re_r;
  assign bus.dir          = dir_r;
  assign bus.ch_wdata     = ch_wdata_r;
  assign bus.err_timeout  = err_timeout_r;
  assign bus.err_unmapped = err_unmapped_r;
endmodule
